// File: rtl/flexbyte_stp_packer.sv
// Packs variable-length byte words into fixed-width output blocks. A block goes out when it fills, on in_last, or on a short word.
// Define FLEXBYTE_STP_PACKER_ERR_EN to enable the sticky err flag for short non-last or oversized in_nbytes words.
module flexbyte_stp_packer #(
  parameter int MSB_FIRST     = 1,
  parameter int NUM_BYTES_IN  = 4,
  parameter int NUM_BYTES_OUT = 16
) (
  input  logic                                   clk,
  input  logic                                   n_rst,
  input  logic                                   clear,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [8*NUM_BYTES_IN-1:0]              data_in,
  input  logic [$clog2(NUM_BYTES_IN+1)-1:0]      in_nbytes,
  input  logic                                   in_last,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [8*NUM_BYTES_OUT-1:0]             data_out,
  output logic [$clog2(NUM_BYTES_OUT+1)-1:0]     out_nbytes,
  output logic                                   err
);

  localparam int OW  = 8 * NUM_BYTES_OUT;
  localparam int OCW = $clog2(NUM_BYTES_OUT + 1);

  generate
    if (NUM_BYTES_OUT <= NUM_BYTES_IN || (NUM_BYTES_OUT % NUM_BYTES_IN) != 0) begin : g_cfg_check
      $fatal(1, "flexbyte_stp_packer: NUM_BYTES_OUT must exceed and be a multiple of NUM_BYTES_IN");
    end
  endgenerate

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [OW-1:0]    blk_q, blk_d;
  logic [OCW-1:0]   cnt_q, cnt_d;
  logic [OCW-1:0]   out_nbytes_q, out_nbytes_d;

  logic             pop, push, partial, eff_last, emit;
  int               nb_raw, nb, base_cnt, new_cnt;
  logic [OW-1:0]    base_blk, filled_blk;

  // Handshake: a word moves when in_valid && in_ready; a block moves when out_valid && out_ready.
  assign out_valid  = (state_q == HOLD);
  assign in_ready   = !out_valid || out_ready;
  assign data_out   = blk_q;
  assign out_nbytes = out_nbytes_q;

  always_comb begin
    nb_raw   = int'(in_nbytes);
    nb       = (nb_raw > NUM_BYTES_IN) ? NUM_BYTES_IN : nb_raw;
    partial  = (nb_raw > 0) && (nb_raw < NUM_BYTES_IN);
    eff_last = in_last || partial;
    pop      = (state_q == HOLD) && out_ready;
    push     = in_valid && in_ready;

    // A push while holding is always paired with a pop, so it starts a fresh block.
    base_blk = (state_q == HOLD) ? '0 : blk_q;
    base_cnt = (state_q == HOLD) ? 0 : int'(cnt_q);

    filled_blk = base_blk;
    for (int k = 0; k < NUM_BYTES_IN; k++) begin
      if (k < nb && (base_cnt + k) < NUM_BYTES_OUT) begin
        if (MSB_FIRST != 0)
          filled_blk[8*(NUM_BYTES_OUT-1-(base_cnt+k)) +: 8] = data_in[8*(NUM_BYTES_IN-1-k) +: 8];
        else
          filled_blk[8*(base_cnt+k) +: 8] = data_in[8*k +: 8];
      end
    end

    new_cnt = base_cnt + nb;
    if (new_cnt > NUM_BYTES_OUT) new_cnt = NUM_BYTES_OUT;
    emit = (new_cnt == NUM_BYTES_OUT) || (eff_last && new_cnt > 0);

    state_d      = state_q;
    blk_d        = blk_q;
    cnt_d        = cnt_q;
    out_nbytes_d = out_nbytes_q;

    if (clear) begin
      state_d      = ACCUM;
      blk_d        = '0;
      cnt_d        = '0;
      out_nbytes_d = '0;
    end else if (push) begin
      blk_d = filled_blk;
      cnt_d = OCW'(new_cnt);
      if (emit) begin
        state_d      = HOLD;
        out_nbytes_d = OCW'(new_cnt);
      end else begin
        state_d      = ACCUM;
        out_nbytes_d = '0;
      end
    end else if (pop) begin
      state_d      = ACCUM;
      blk_d        = '0;
      cnt_d        = '0;
      out_nbytes_d = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ACCUM;
      blk_q        <= '0;
      cnt_q        <= '0;
      out_nbytes_q <= '0;
    end else begin
      state_q      <= state_d;
      blk_q        <= blk_d;
      cnt_q        <= cnt_d;
      out_nbytes_q <= out_nbytes_d;
    end
  end

`ifdef FLEXBYTE_STP_PACKER_ERR_EN
  logic err_q, err_d;
  logic oversize;

  always_comb begin
    oversize = nb_raw > NUM_BYTES_IN;
    err_d    = err_q;
    if (clear)
      err_d = 1'b0;
    else if (push && (oversize || (partial && !in_last)))
      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_flexbyte_stp_packer.sv
// Bench for flexbyte_stp_packer: an MSB-first and an LSB-first instance share stimulus and are checked against a byte-queue model.
module tb_flexbyte_stp_packer;

  localparam int NBI = 4;
  localparam int NBO = 16;
`ifdef FLEXBYTE_STP_PACKER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic              clear = 1'b0;
  logic              in_valid = 1'b0;
  logic [8*NBI-1:0]  data_in = '0;
  logic [2:0]        in_nbytes = '0;
  logic              in_last = 1'b0;
  logic              out_ready = 1'b0;

  logic              in_ready_m, out_valid_m, err_m;
  logic [8*NBO-1:0]  data_out_m;
  logic [4:0]        out_nbytes_m;
  logic              in_ready_l, out_valid_l, err_l;
  logic [8*NBO-1:0]  data_out_l;
  logic [4:0]        out_nbytes_l;

  flexbyte_stp_packer #(.MSB_FIRST(1), .NUM_BYTES_IN(NBI), .NUM_BYTES_OUT(NBO)) dut_m (
    .clk(clk), .n_rst(n_rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_m),
    .data_in(data_in), .in_nbytes(in_nbytes), .in_last(in_last), .out_valid(out_valid_m),
    .out_ready(out_ready), .data_out(data_out_m), .out_nbytes(out_nbytes_m), .err(err_m)
  );

  flexbyte_stp_packer #(.MSB_FIRST(0), .NUM_BYTES_IN(NBI), .NUM_BYTES_OUT(NBO)) dut_l (
    .clk(clk), .n_rst(n_rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready_l),
    .data_in(data_in), .in_nbytes(in_nbytes), .in_last(in_last), .out_valid(out_valid_l),
    .out_ready(out_ready), .data_out(data_out_l), .out_nbytes(out_nbytes_l), .err(err_l)
  );

  // ---------------- scoreboard / model ----------------
  int vectors = 0;
  int miscompares = 0;

  logic [7:0] cur_m[$];
  logic [7:0] cur_l[$];
  bit         m_hold = 1'b0;
  bit         m_err = 1'b0;
  bit         m_pop, m_push, m_part;
  int         m_n;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] expect_blk(input bit msb);
    logic [127:0] v;
    int n;
    v = '0;
    n = msb ? cur_m.size() : cur_l.size();
    for (int i = 0; i < n; i++) begin
      if (msb) v = (v << 8) | 128'(cur_m[i]);
      else     v = v | (128'(cur_l[i]) << (8 * i));
    end
    if (msb && n > 0) v = v << (8 * (NBO - n));
    return v;
  endfunction

  always @(negedge n_rst) begin
    cur_m.delete();
    cur_l.delete();
    m_hold = 1'b0;
    m_err  = 1'b0;
  end

  always @(posedge clk) begin
    if (n_rst) begin
      if (clear) begin
        cur_m.delete();
        cur_l.delete();
        m_hold = 1'b0;
        m_err  = 1'b0;
      end else begin
        m_pop  = m_hold && out_ready;
        m_push = in_valid && (!m_hold || out_ready);
        if (m_pop) begin
          cur_m.delete();
          cur_l.delete();
          m_hold = 1'b0;
        end
        if (m_push) begin
          m_n    = (int'(in_nbytes) > NBI) ? NBI : int'(in_nbytes);
          m_part = (in_nbytes != 0) && (int'(in_nbytes) < NBI);
          for (int k = 0; k < m_n; k++) begin
            cur_m.push_back(8'((data_in >> (8 * (NBI - 1 - k))) & 32'hFF));
            cur_l.push_back(8'((data_in >> (8 * k)) & 32'hFF));
          end
          if (ERR_EN && (int'(in_nbytes) > NBI || (m_part && !in_last))) m_err = 1'b1;
          if (cur_m.size() == NBO || ((in_last || m_part) && cur_m.size() > 0)) m_hold = 1'b1;
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (n_rst) begin
      chk("in_ready_m",   128'(in_ready_m),   128'(!m_hold || out_ready));
      chk("in_ready_l",   128'(in_ready_l),   128'(!m_hold || out_ready));
      chk("out_valid_m",  128'(out_valid_m),  128'(m_hold));
      chk("out_valid_l",  128'(out_valid_l),  128'(m_hold));
      chk("out_nbytes_m", 128'(out_nbytes_m), m_hold ? 128'(cur_m.size()) : 128'(0));
      chk("out_nbytes_l", 128'(out_nbytes_l), m_hold ? 128'(cur_l.size()) : 128'(0));
      chk("err_m",        128'(err_m),        128'(m_err));
      chk("err_l",        128'(err_l),        128'(m_err));
      if (m_hold) begin
        chk("data_out_m", data_out_m, expect_blk(1'b1));
        chk("data_out_l", data_out_l, expect_blk(1'b0));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] d, input logic [2:0] n, input bit last);
    int waited;
    waited    = 0;
    in_valid  = 1'b1;
    data_in   = d;
    in_nbytes = n;
    in_last   = last;
    @(negedge clk);
    while (!in_ready_m && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready_m) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: in_ready stuck at 0 for word %0h", d);
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_nbytes = '0;
    in_last   = 1'b0;
  endtask

  task automatic pop_block();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic send_seq4(input logic [31:0] base);
    for (int i = 0; i < 4; i++) send_word(base + 32'(i) * 32'h04040404, 3'd4, 1'b0);
  endtask

  localparam logic [127:0] BLK_A_M = 128'h000102030405060708090A0B0C0D0E0F;
  localparam logic [127:0] BLK_A_L = 128'h0C0D0E0F08090A0B0405060700010203;

  // ---------------- directed + random stimulus ----------------
  initial begin
    #3;
    chk("rst_out_valid",  128'(out_valid_m),  128'(0));
    chk("rst_in_ready",   128'(in_ready_m),   128'(1));
    chk("rst_data_out",   data_out_m,         128'(0));
    chk("rst_out_nbytes", 128'(out_nbytes_m), 128'(0));
    chk("rst_err",        128'(err_m),        128'(0));
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    @(posedge clk); #1;

    // Four full words, both byte orders
    send_seq4(32'h00010203);
    chk("t1_valid",   128'(out_valid_m),  128'(1));
    chk("t1_data_m",  data_out_m,         BLK_A_M);
    chk("t1_data_l",  data_out_l,         BLK_A_L);
    chk("t1_nbytes",  128'(out_nbytes_m), 128'(16));

    // Back-pressure: block held, input stalled
    repeat (5) begin
      @(negedge clk);
      chk("t2_in_ready", 128'(in_ready_m), 128'(0));
      chk("t2_hold",     data_out_m,       BLK_A_M);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_word(32'h10111213, 3'd4, 1'b0);
    out_ready = 1'b0;
    chk("t2_after_swap_valid", 128'(out_valid_m), 128'(0));
    send_word(32'h14151617, 3'd4, 1'b0);
    send_word(32'h18191A1B, 3'd4, 1'b0);
    chk("t2_not_yet_full", 128'(out_valid_m), 128'(0));
    send_word(32'h1C1D1E1F, 3'd4, 1'b0);
    chk("t2_block2", data_out_m, 128'h101112131415161718191A1B1C1D1E1F);
    pop_block();

    // Partial block on in_last
    send_word(32'hAABBCCDD, 3'd4, 1'b0);
    send_word(32'h11220000, 3'd2, 1'b1);
    chk("t3_data_m", data_out_m, {48'hAABBCCDD1122, 80'h0});
    chk("t3_nbytes", 128'(out_nbytes_m), 128'(6));
    pop_block();

    // Short non-last word is treated as last and flagged when enabled
    send_word(32'h12345678, 3'd2, 1'b0);
    chk("t4_valid",  128'(out_valid_m),  128'(1));
    chk("t4_nbytes", 128'(out_nbytes_m), 128'(2));
    chk("t4_data_m", data_out_m,         {16'h1234, 112'h0});
    chk("t4_err",    128'(err_m),        128'(ERR_EN));
    pop_block();
    chk("t4_err_sticky", 128'(err_m), 128'(ERR_EN));
    do_clear();
    chk("t4_err_clear", 128'(err_m), 128'(0));

    // Zero-byte words: no-op, and last with empty buffer emits nothing
    send_word(32'hDEADBEEF, 3'd0, 1'b0);
    send_word(32'hDEADBEEF, 3'd0, 1'b1);
    chk("t5_empty_last", 128'(out_valid_m), 128'(0));
    send_word(32'hCAFEF00D, 3'd4, 1'b0);
    send_word(32'h00000000, 3'd0, 1'b1);
    chk("t5_flush_nbytes", 128'(out_nbytes_m), 128'(4));
    pop_block();

    // Oversized count clamps to a full word
    send_word(32'h01020304, 3'd7, 1'b0);
    send_word(32'h05060708, 3'd4, 1'b0);
    send_word(32'h090A0B0C, 3'd4, 1'b0);
    send_word(32'h0D0E0F10, 3'd4, 1'b0);
    chk("t6_clamp_nbytes", 128'(out_nbytes_m), 128'(16));
    pop_block();
    do_clear();

    // Clear mid-block discards partial data
    send_word(32'hFFFFFFFF, 3'd4, 1'b0);
    send_word(32'hEEEEEEEE, 3'd4, 1'b0);
    do_clear();
    send_seq4(32'h00010203);
    chk("t7_after_clear", data_out_m, BLK_A_M);
    pop_block();

    // Asynchronous reset mid-block
    send_word(32'h55555555, 3'd4, 1'b0);
    send_word(32'h66666666, 3'd4, 1'b0);
    #2 n_rst = 1'b0;
    #1;
    chk("t8_rst_valid",  128'(out_valid_m),  128'(0));
    chk("t8_rst_data",   data_out_m,         128'(0));
    chk("t8_rst_nbytes", 128'(out_nbytes_m), 128'(0));
    chk("t8_rst_ready",  128'(in_ready_m),   128'(1));
    chk("t8_rst_err",    128'(err_m),        128'(0));
    @(posedge clk); #1 n_rst = 1'b1;
    send_seq4(32'h00010203);
    chk("t8_clean_block", data_out_m, BLK_A_M);
    chk("t8_clean_block_l", data_out_l, BLK_A_L);
    pop_block();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      int r;
      in_valid  = ($urandom_range(0, 3) != 0);
      data_in   = $urandom;
      r         = $urandom_range(0, 19);
      in_nbytes = (r < 14) ? 3'd4 : 3'(r - 14);
      in_last   = ($urandom_range(0, 15) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      clear     = ($urandom_range(0, 99) == 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    clear     = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
